mem_stage_lsu: RTL and testbench

- Memory-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result (address), RD2 (store data), instruction (funct3) and MEM control bits.
- Drives a data memory over a req/ready handshake and stalls the pipeline while an access is outstanding.
- Returns byte/half/word-aligned, sign- or zero-extended load data for the MEM/WB register.

---
 rtl/mem_stage_lsu_pkg.sv | 22 ++
 rtl/mem_stage_lsu_load_align.sv | 26 ++
 rtl/mem_stage_lsu.sv | 120 ++++++++++++
 tb/tb_mem_stage_lsu.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - shared types and constants for the memory-stage load/store unit
package mem_stage_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int MEMWRITE_BIT = 0;
   localparam int MEMREAD_BIT  = 1;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// rtl/mem_stage_lsu_load_align.sv - extracts and extends a byte/half/word from a 32-bit read beat
module mem_load_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   result = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  result = {24'h0, byte_sel};
         F3_LHU:  result = {16'h0, half_sel};
         default: result = rdata;  // LW and undefined encodings pass the word through
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage LSU: req/ready data memory access with pipeline stall
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] aluout_in,
   input  logic [DATA_W-1:0] RD2_in,
   input  logic [31:0]       inst_in,
   input  logic [4:0]        MEM_signal_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_out,
   output logic [DATA_W-1:0] load_data_out,
   output logic              load_valid,
   output logic              misalign_out
);

   lsu_state_t        state;
   logic [2:0]        funct3;
   logic              is_write;
   logic              is_read;
   logic              access;
   logic              misaligned;
   logic [3:0]        be_next;
   logic [DATA_W-1:0] wdata_next;
   logic [2:0]        funct3_q;
   logic [1:0]        addr_lo_q;
   logic [31:0]       load_ext;
   logic              unused_bits;

   assign funct3      = inst_in[14:12];
   assign is_write    = MEM_signal_in[MEMWRITE_BIT];
   assign is_read     = MEM_signal_in[MEMREAD_BIT];
   assign access      = is_write | is_read;
   assign unused_bits = ^{inst_in[31:15], inst_in[11:0], MEM_signal_in[4:2]};

   assign misaligned = ((funct3[1:0] == F3_SH[1:0]) && aluout_in[0]) ||
                       ((funct3[1:0] == F3_SW[1:0]) && (aluout_in[1:0] != 2'b00));

   assign stall_out    = (state == BUSY) || ((state == IDLE) && access && !misaligned);
   assign misalign_out = (state == IDLE) && access && misaligned;

   // Lane steering is shared by loads and stores so the enables describe the bytes touched.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = RD2_in;
      case (funct3[1:0])
         F3_SB[1:0]: begin
            be_next    = 4'b0001 << aluout_in[1:0];
            wdata_next = {4{RD2_in[7:0]}};
         end
         F3_SH[1:0]: begin
            be_next    = aluout_in[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{RD2_in[15:0]}};
         end
         default: ;
      endcase
   end

   mem_load_align u_load_align (
      .rdata   (mem_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .result  (load_ext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_be        <= 4'b0000;
         mem_wdata     <= '0;
         funct3_q      <= 3'b000;
         addr_lo_q     <= 2'b00;
         load_data_out <= '0;
         load_valid    <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (access && !misaligned) begin
                  mem_req   <= 1'b1;
                  mem_we    <= is_write;
                  mem_addr  <= {aluout_in[ADDR_W-1:2], 2'b00};
                  mem_be    <= be_next;
                  mem_wdata <= wdata_next;
                  funct3_q  <= funct3;
                  addr_lo_q <= aluout_in[1:0];
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     load_data_out <= load_ext;
                     load_valid    <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            // EX/MEM still holds the finished instruction here, so never re-accept it.
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] aluout_in = '0;
   logic [31:0] RD2_in = '0;
   logic [31:0] inst_in = '0;
   logic [4:0]  MEM_signal_in = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        stall_out;
   logic [31:0] load_data_out;
   logic        load_valid;
   logic        misalign_out;

   int checks = 0;
   int errors = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;

   localparam logic [4:0] SIG_NONE = 5'b00000;
   localparam logic [4:0] SIG_WR   = 5'b00001;
   localparam logic [4:0] SIG_RD   = 5'b00010;

   mem_stage_lsu dut (
      .clk           (clk),
      .rst           (rst),
      .aluout_in     (aluout_in),
      .RD2_in        (RD2_in),
      .inst_in       (inst_in),
      .MEM_signal_in (MEM_signal_in),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_be        (mem_be),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ready     (mem_ready),
      .stall_out     (stall_out),
      .load_data_out (load_data_out),
      .load_valid    (load_valid),
      .misalign_out  (misalign_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_req && !req_prev) req_rises <= req_rises + 1;
      req_prev <= mem_req;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one access and plays the memory; returns while the unit sits in RESP.
   task automatic run_access(
      input  logic [31:0] a,
      input  logic [31:0] d,
      input  logic [2:0]  f3,
      input  logic [4:0]  sig,
      input  logic [31:0] rd,
      input  int          wait_n,
      output int          stalls,
      output logic        lv,
      output logic [31:0] ld,
      output logic        stable,
      output logic [31:0] q_addr,
      output logic [31:0] q_wdata,
      output logic [3:0]  q_be,
      output logic        q_we
   );
      int   busy;
      logic seen;
      logic done;
      aluout_in     = a;
      RD2_in        = d;
      inst_in       = {17'h0, f3, 12'h0};
      MEM_signal_in = sig;
      mem_rdata     = rd;
      stalls = 0; lv = 1'b0; ld = '0; stable = 1'b1;
      q_addr = '0; q_wdata = '0; q_be = '0; q_we = 1'b0;
      busy = 0; seen = 1'b0; done = 1'b0;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (seen && !mem_req) begin
            lv   = load_valid;
            ld   = load_data_out;
            done = 1'b1;
            break;
         end
         if (stall_out) stalls++;
         if (mem_req) begin
            if (!seen) begin
               q_addr = mem_addr; q_wdata = mem_wdata; q_be = mem_be; q_we = mem_we;
            end else if (mem_addr !== q_addr || mem_wdata !== q_wdata ||
                         mem_be !== q_be || mem_we !== q_we) begin
               stable = 1'b0;
            end
            seen      = 1'b1;
            mem_ready = (busy >= wait_n);
            busy++;
         end else begin
            mem_ready = 1'b0;
         end
         step();
      end
      mem_ready = 1'b0;
      if (!done) check("access_timeout", 32'd0, 32'd1);
   endtask

   int          st;
   logic        lv, stb, we;
   logic [31:0] ld, qa, qd;
   logic [3:0]  qb;
   int          r0;

   initial begin
      step();
      step();
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_load_data", load_data_out, 0);
      check("rst_load_valid", load_valid, 0);
      check("rst_stall", stall_out, 0);
      check("rst_misalign", misalign_out, 0);
      rst = 1'b0;
      step();

      // LW 0x100, ready on first BUSY cycle
      run_access(32'h100, 32'h0, 3'b010, SIG_RD, 32'hDEADBEEF, 0, st, lv, ld, stb, qa, qd, qb, we);
      check("lw_addr", qa, 32'h100);
      check("lw_be", qb, 4'b1111);
      check("lw_we", we, 0);
      check("lw_stall_cycles", st, 2);
      check("lw_valid", lv, 1);
      check("lw_data", ld, 32'hDEADBEEF);
      MEM_signal_in = SIG_NONE;
      step();
      check("lw_valid_pulse", load_valid, 0);

      // LB then LBU at 0x103
      run_access(32'h103, 32'h0, 3'b000, SIG_RD, 32'h80FFFF7F, 0, st, lv, ld, stb, qa, qd, qb, we);
      check("lb_addr", qa, 32'h100);
      check("lb_be", qb, 4'b1000);
      check("lb_data", ld, 32'hFFFFFF80);
      MEM_signal_in = SIG_NONE;
      step();
      run_access(32'h103, 32'h0, 3'b100, SIG_RD, 32'h80123456, 0, st, lv, ld, stb, qa, qd, qb, we);
      check("lbu_valid", lv, 1);
      check("lbu_data", ld, 32'h00000080);
      MEM_signal_in = SIG_NONE;
      step();

      // SH 0x102 with three wait cycles
      run_access(32'h102, 32'h1234ABCD, 3'b001, SIG_WR, 32'h0, 3, st, lv, ld, stb, qa, qd, qb, we);
      check("sh_addr", qa, 32'h100);
      check("sh_be", qb, 4'b1100);
      check("sh_wdata", qd, 32'hABCDABCD);
      check("sh_we", we, 1);
      check("sh_stable", stb, 1);
      check("sh_stall_cycles", st, 5);
      check("sh_no_valid", lv, 0);
      check("sh_load_held", ld, 32'h00000080);
      MEM_signal_in = SIG_NONE;
      step();

      // Misaligned LW 0x101
      r0 = req_rises;
      aluout_in = 32'h101; inst_in = {17'h0, 3'b010, 12'h0}; MEM_signal_in = SIG_RD;
      #1;
      check("mis_flag", misalign_out, 1);
      check("mis_stall", stall_out, 0);
      step();
      step();
      check("mis_no_req", mem_req, 0);
      check("mis_req_count", req_rises - r0, 0);
      MEM_signal_in = SIG_NONE;
      step();

      // Back-to-back SW then LW
      r0 = req_rises;
      run_access(32'h200, 32'hCAFEF00D, 3'b010, SIG_WR, 32'h0, 0, st, lv, ld, stb, qa, qd, qb, we);
      check("sw_be", qb, 4'b1111);
      check("sw_wdata", qd, 32'hCAFEF00D);
      step();
      run_access(32'h204, 32'h0, 3'b010, SIG_RD, 32'h11223344, 1, st, lv, ld, stb, qa, qd, qb, we);
      check("b2b_lw_addr", qa, 32'h204);
      check("b2b_lw_data", ld, 32'h11223344);
      check("b2b_lw_stall", st, 3);
      MEM_signal_in = SIG_NONE;
      step();
      step();
      check("b2b_req_count", req_rises - r0, 2);

      // Reset on the second BUSY cycle of a load
      aluout_in = 32'h300; inst_in = {17'h0, 3'b010, 12'h0}; MEM_signal_in = SIG_RD;
      mem_ready = 1'b0;
      step();
      check("rstmid_req", mem_req, 1);
      step();
      rst = 1'b1;
      step();
      check("rstmid_req_clr", mem_req, 0);
      check("rstmid_valid", load_valid, 0);
      check("rstmid_data", load_data_out, 0);
      MEM_signal_in = SIG_NONE;
      #1;
      check("rstmid_stall", stall_out, 0);
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
